// File: rtl/jesd204b_dll_rx_lane.sv
// JESD204B per-lane data link layer receiver: CGS, ILAS checking and
// control-character replacement for one 4-octet frame per clock.
module jesd204b_dll_rx_lane #(
  parameter int unsigned FRAMES_PER_MF    = 4,
  parameter int unsigned ILAS_MULTIFRAMES = 4,
  parameter int unsigned ERR_CNT_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              rx_data,
  input  logic [3:0]               rx_charisk,
  output logic                     sync_n,
  output logic [31:0]              data_out,
  output logic                     data_valid,
  output logic                     ilas_done,
  output logic                     ilas_err,
  output logic                     err_unexp_k,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [1:0] CgsInit  = 2'd0;
  localparam logic [1:0] CgsCheck = 2'd1;
  localparam logic [1:0] Ilas     = 2'd2;
  localparam logic [1:0] Data     = 2'd3;

  localparam logic [4:0] KLast = 5'(FRAMES_PER_MF - 1);
  localparam logic [2:0] MLast = 3'(ILAS_MULTIFRAMES - 1);

  logic [1:0]               state_q, state_d;
  logic [4:0]               frame_q, frame_d;
  logic [2:0]               mf_q, mf_d;
  logic [7:0]               prev_q, prev_d;
  logic                     sync_n_q, sync_n_d;
  logic [31:0]              data_out_q, data_out_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     ilas_err_q, ilas_err_d;
  logic                     unexp_q, unexp_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        kword, is_r, is_q, is_a0, is_f0;
  logic        ilas_chk, viol, bad;
  logic [4:0]  f_cur;
  logic [2:0]  m_cur;
  logic [31:0] out_word;

  assign kword = (rx_charisk == 4'hF) && (rx_data == 32'hBCBCBCBC);
  assign is_r  = rx_charisk[3] && (rx_data[31:24] == 8'h1C);
  assign is_q  = rx_charisk[2] && (rx_data[23:16] == 8'h9C);
  assign is_a0 = rx_charisk[0] && (rx_data[7:0] == 8'h7C);
  assign is_f0 = rx_charisk[0] && (rx_data[7:0] == 8'hFC);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    mf_d       = mf_q;
    prev_d     = prev_q;
    data_out_d = '0;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    ilas_err_d = 1'b0;
    unexp_d    = 1'b0;
    cnt_d      = cnt_q;
    ilas_chk   = 1'b0;
    viol       = 1'b0;
    bad        = 1'b0;
    f_cur      = '0;
    m_cur      = '0;
    out_word   = rx_data;

    case (state_q)
      CgsInit: begin
        if (kword) state_d = CgsCheck;
      end
      CgsCheck: begin
        // The first /R/ word is frame 0 of multiframe 0 and goes through the ILAS checks.
        if (!kword) begin
          if (is_r) ilas_chk = 1'b1;
          else      state_d  = CgsInit;
        end
      end
      Ilas: begin
        ilas_chk = 1'b1;
        f_cur    = frame_q;
        m_cur    = mf_q;
      end
      default: begin
        if (kword) begin
          state_d = CgsInit;
        end else begin
          valid_d = 1'b1;
          done_d  = 1'b1;
          if (rx_charisk[0]) begin
            if ((frame_q != KLast && is_f0) || (frame_q == KLast && is_a0)) begin
              out_word[7:0] = prev_q;
            end else begin
              bad = 1'b1;
            end
          end
          if (|rx_charisk[3:1]) bad = 1'b1;
          unexp_d = bad;
          if (bad && (cnt_q != {ERR_CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
          prev_d     = out_word[7:0];
          data_out_d = out_word;
          frame_d    = (frame_q == KLast) ? 5'd0 : frame_q + 5'd1;
        end
      end
    endcase

    if (ilas_chk) begin
      viol = ((f_cur == 5'd0) && !is_r) ||
             ((f_cur == KLast) && !is_a0) ||
             ((m_cur == 3'd1) && (f_cur == 5'd0) && !is_q);
      if (viol) begin
        ilas_err_d = 1'b1;
        state_d    = CgsInit;
      end else if (f_cur == KLast) begin
        frame_d = 5'd0;
        if (m_cur == MLast) begin
          state_d = Data;
          mf_d    = 3'd0;
          prev_d  = 8'd0;
        end else begin
          state_d = Ilas;
          mf_d    = m_cur + 3'd1;
        end
      end else begin
        state_d = Ilas;
        frame_d = f_cur + 5'd1;
        mf_d    = m_cur;
      end
    end

    sync_n_d = (state_d != CgsInit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CgsInit;
      frame_q    <= '0;
      mf_q       <= '0;
      prev_q     <= '0;
      sync_n_q   <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ilas_err_q <= 1'b0;
      unexp_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      mf_q       <= mf_d;
      prev_q     <= prev_d;
      sync_n_q   <= sync_n_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      ilas_err_q <= ilas_err_d;
      unexp_q    <= unexp_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sync_n      = sync_n_q;
  assign data_out    = data_out_q;
  assign data_valid  = valid_q;
  assign ilas_done   = done_q;
  assign ilas_err    = ilas_err_q;
  assign err_unexp_k = unexp_q;
  assign err_count   = cnt_q;

endmodule
